// File: rtl/regfile_pkg.sv
// Shared widths, address type and helpers for the integer register file.
package regfile_pkg;

    localparam int XLEN       = 32;
    localparam int NREG       = 32;
    localparam int REG_ADDR_W = $clog2(NREG);

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;
    typedef xlen_t [NREG-1:0]      reg_array_t;

    localparam reg_addr_t ZERO_REG = reg_addr_t'(0);

    // Only false when NREG is not a power of two and the address falls past the last register.
    function automatic logic addr_valid(input reg_addr_t a);
        return int'(a) < NREG;
    endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: x0 and out-of-range read zero, a live write bypasses storage.
module regfile_rdport
    import regfile_pkg::*;
(
    input  reg_addr_t  addr,
    input  reg_array_t regs,
    input  reg_addr_t  rd,
    input  xlen_t      indata,
    input  logic       wr_en,
    output xlen_t      value
);

    always_comb begin
        value = '0;
        if (addr == ZERO_REG || !addr_valid(addr)) begin
            value = '0;
        end else if (wr_en && rd == addr) begin
            value = indata;
        end else begin
            value = regs[addr];
        end
    end

endmodule

// File: rtl/regfile.sv
// RV32 integer register file: two async read ports with write bypass, one sync write port.
module regfile
    import regfile_pkg::*;
(
    input  logic      CLK,
    input  logic      RST_N,
    input  reg_addr_t rs1,
    input  reg_addr_t rs2,
    input  reg_addr_t rd,
    input  xlen_t     indata,
    input  logic      RegWrite,
    output xlen_t     rs1_value,
    output xlen_t     rs2_value
);

    reg_array_t regs_q;
    logic       wr_en;

    // Gating with reset keeps the bypass from leaking writeback data while the file is held clear.
    assign wr_en = RegWrite & RST_N;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            regs_q <= '0;
        end else if (RegWrite && rd != ZERO_REG && addr_valid(rd)) begin
            regs_q[rd] <= indata;
        end
    end

    regfile_rdport u_rd1 (
        .addr   (rs1),
        .regs   (regs_q),
        .rd     (rd),
        .indata (indata),
        .wr_en  (wr_en),
        .value  (rs1_value)
    );

    regfile_rdport u_rd2 (
        .addr   (rs2),
        .regs   (regs_q),
        .rd     (rd),
        .indata (indata),
        .wr_en  (wr_en),
        .value  (rs2_value)
    );

endmodule

// File: tb/tb_regfile.sv
// Bench for regfile: directed table, reset and sweep sequences, then random traffic vs. an array model.
module tb_regfile;

    logic        CLK;
    logic        RST_N;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] indata;
    logic        RegWrite;
    logic [31:0] rs1_value, rs2_value;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] model [32];

    regfile dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .indata    (indata),
        .RegWrite  (RegWrite),
        .rs1_value (rs1_value),
        .rs2_value (rs2_value)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        we;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    vec_t tbl [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Architectural read: zero register, then same-cycle write, then stored value.
    function automatic logic [31:0] ref_read(input logic [4:0] a, input logic [4:0] w,
                                             input logic [31:0] d, input logic en);
        if (a == 5'd0) return 32'h0;
        if (en && a == w) return d;
        return model[a];
    endfunction

    task automatic apply(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] w,
                         input logic [31:0] d, input logic en);
        rs1 = a1; rs2 = a2; rd = w; indata = d; RegWrite = en;
    endtask

    task automatic clock_in();
        @(posedge CLK);
        if (RegWrite && rd != 5'd0) model[rd] = indata;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        apply(5'd0, 5'd0, 5'd0, 32'h0, 1'b0);
        RST_N = 1'b0;
        #2;
        check("reset_rs1", rs1_value, 32'h0);
        check("reset_rs2", rs2_value, 32'h0);
        @(posedge CLK); #1;
        RST_N = 1'b1;
        @(posedge CLK); #1;

        tbl[0]  = '{5'd3, 5'd0, 5'd3, 32'h32,       1'b1, 32'h32,       32'h0};
        tbl[1]  = '{5'd3, 5'd1, 5'd1, 32'h12,       1'b1, 32'h32,       32'h12};
        tbl[2]  = '{5'd3, 5'd1, 5'd3, 32'h0,        1'b0, 32'h32,       32'h12};
        tbl[3]  = '{5'd1, 5'd5, 5'd5, 32'h10,       1'b1, 32'h12,       32'h10};
        tbl[4]  = '{5'd5, 5'd5, 5'd0, 32'h0,        1'b0, 32'h10,       32'h10};
        tbl[5]  = '{5'd0, 5'd0, 5'd0, 32'hDEADBEEF, 1'b1, 32'h0,        32'h0};
        tbl[6]  = '{5'd0, 5'd0, 5'd0, 32'hDEADBEEF, 1'b0, 32'h0,        32'h0};
        tbl[7]  = '{5'd3, 5'd3, 5'd3, 32'hFFFFFFFF, 1'b0, 32'h32,       32'h32};
        tbl[8]  = '{5'd3, 5'd3, 5'd3, 32'hFFFFFFFF, 1'b0, 32'h32,       32'h32};
        tbl[9]  = '{5'd3, 5'd3, 5'd3, 32'hFFFFFFFF, 1'b0, 32'h32,       32'h32};
        tbl[10] = '{5'd7, 5'd7, 5'd7, 32'hA5A5A5A5, 1'b1, 32'hA5A5A5A5, 32'hA5A5A5A5};
        tbl[11] = '{5'd7, 5'd3, 5'd9, 32'h0,        1'b0, 32'hA5A5A5A5, 32'h32};
        tbl[12] = '{5'd31, 5'd7, 5'd7, 32'h5,       1'b1, 32'h0,        32'h5};

        for (int i = 0; i < 13; i++) begin
            apply(tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].data, tbl[i].we);
            #2;
            check($sformatf("tbl%0d_rs1", i), rs1_value, tbl[i].e1);
            check($sformatf("tbl%0d_rs2", i), rs2_value, tbl[i].e2);
            clock_in();
        end

        // Asynchronous reset mid-cycle with a write pending: no bypass, no write, clears x3.
        apply(5'd3, 5'd3, 5'd3, 32'h77, 1'b1);
        #1;
        RST_N = 1'b0;
        #1;
        check("rst_async_rs1", rs1_value, 32'h0);
        check("rst_nobypass_rs2", rs2_value, 32'h0);
        @(posedge CLK); #1;
        RST_N = 1'b1;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        apply(5'd3, 5'd7, 5'd0, 32'h0, 1'b0);
        #1;
        check("rst_release_x3", rs1_value, 32'h0);
        check("rst_release_x7", rs2_value, 32'h0);
        clock_in();

        // Full sweep of every register, read back as mirrored pairs.
        for (int i = 1; i < 32; i++) begin
            apply(5'd0, 5'd0, 5'(i), 32'(i) * 32'h01010101, 1'b1);
            clock_in();
        end
        for (int i = 0; i < 32; i++) begin
            apply(5'(i), 5'(31 - i), 5'd0, 32'h0, 1'b0);
            #1;
            check($sformatf("sweep_rs1_x%0d", i), rs1_value, 32'(i) * 32'h01010101);
            check($sformatf("sweep_rs2_x%0d", 31 - i), rs2_value, 32'(31 - i) * 32'h01010101);
        end
        clock_in();

        // Random traffic, biased so reads often hit the register being written.
        for (int n = 0; n < 400; n++) begin
            logic [4:0]  w, a1, a2;
            logic [31:0] d;
            logic        en;
            w  = 5'($urandom_range(0, 31));
            d  = $urandom;
            en = ($urandom_range(0, 3) != 0);
            a1 = ($urandom_range(0, 3) == 0) ? w : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 3) == 0) ? w : 5'($urandom_range(0, 31));
            apply(a1, a2, w, d, en);
            #2;
            check($sformatf("rnd%0d_rs1", n), rs1_value, ref_read(a1, w, d, en));
            check($sformatf("rnd%0d_rs2", n), rs2_value, ref_read(a2, w, d, en));
            clock_in();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
